// File: rtl/ram_access_ctrl.sv
// Host-to-RAM access controller: valid/ready requests in, sequenced RAM strobes out,
// registered read responses back. Optional macro RAM_INIT_EN zero-fills the RAM after reset.
module ram_access_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_BUS_WIDTH = 8,
  parameter int unsigned MAX_MEM_LOC    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [ADDR_BUS_WIDTH-1:0] rsp_addr,
  output logic                      busy,
  output logic                      read_en,
  output logic                      write_en,
  output logic [ADDR_BUS_WIDTH-1:0] address_loc,
  output logic [DATA_WIDTH-1:0]     data_in,
  input  logic [DATA_WIDTH-1:0]     ram_rdata
);

`ifdef RAM_INIT_EN
  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_WR, S_RD_ISSUE, S_RD_CAPT, S_RSP, S_INIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_WR, S_RD_ISSUE, S_RD_CAPT, S_RSP
  } state_t;
`endif

  localparam logic [ADDR_BUS_WIDTH-1:0] LAST_ADDR = ADDR_BUS_WIDTH'(MAX_MEM_LOC);

  state_t                    state, state_d;
  logic                      req_ready_d, busy_d, read_en_d, write_en_d, rsp_valid_d;
  logic [ADDR_BUS_WIDTH-1:0] address_loc_d, rsp_addr_d;
  logic [DATA_WIDTH-1:0]     data_in_d, rsp_rdata_d;

  // State and all outputs registered; outputs are computed from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      req_ready   <= 1'b0;
      busy        <= 1'b1;
      read_en     <= 1'b0;
      write_en    <= 1'b0;
      address_loc <= '0;
      data_in     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_addr    <= '0;
    end else begin
      state       <= state_d;
      req_ready   <= req_ready_d;
      busy        <= busy_d;
      read_en     <= read_en_d;
      write_en    <= write_en_d;
      address_loc <= address_loc_d;
      data_in     <= data_in_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_addr    <= rsp_addr_d;
    end
  end

  // Next-state and next-output logic; strobes default low so each lasts one cycle.
  always_comb begin
    state_d       = state;
    read_en_d     = 1'b0;
    write_en_d    = 1'b0;
    address_loc_d = address_loc;
    data_in_d     = data_in;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_addr_d    = rsp_addr;

    case (state)
      S_RESET: begin
`ifdef RAM_INIT_EN
        state_d       = S_INIT;
        write_en_d    = 1'b1;
        address_loc_d = '0;
        data_in_d     = '0;
`else
        state_d       = S_IDLE;
`endif
      end
`ifdef RAM_INIT_EN
      // Zero-fill sweep reuses address_loc as the counter.
      S_INIT: begin
        if (address_loc == LAST_ADDR) begin
          state_d = S_IDLE;
        end else begin
          write_en_d    = 1'b1;
          address_loc_d = address_loc + ADDR_BUS_WIDTH'(1);
          data_in_d     = '0;
        end
      end
`endif
      S_IDLE: begin
        if (req_valid && req_ready) begin
          address_loc_d = req_addr;
          if (req_write) begin
            state_d    = S_WR;
            write_en_d = 1'b1;
            data_in_d  = req_wdata;
          end else begin
            state_d   = S_RD_ISSUE;
            read_en_d = 1'b1;
          end
        end
      end
      S_WR:       state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_CAPT;
      // RAM output is registered one edge after read_en; capture it here.
      S_RD_CAPT: begin
        state_d     = S_RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ram_rdata;
        rsp_addr_d  = address_loc;
      end
      S_RSP: begin
        if (rsp_valid && rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl with a behavioural single-port RAM.
`timescale 1ns/1ps
module tb_ram_access_ctrl;
  logic       clk, rst_n;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata, rsp_addr;
  logic       busy, read_en, write_en;
  logic [7:0] address_loc, data_in, ram_rdata;

  int pass_cnt = 0;
  int check_cnt = 0;
  int overlap_cnt = 0;

  logic [7:0] mem [0:255];

  ram_access_ctrl #(.DATA_WIDTH(8), .ADDR_BUS_WIDTH(8), .MAX_MEM_LOC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .busy(busy), .read_en(read_en), .write_en(write_en),
    .address_loc(address_loc), .data_in(data_in), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM with registered read data
  always @(posedge clk) begin
    if (write_en) mem[address_loc] <= data_in;
    if (read_en) ram_rdata <= mem[address_loc];
  end

  always @(negedge clk) if (rst_n && read_en && write_en) overlap_cnt++;

  // Drive one request; returns 1 ns after the handshake edge.
  task automatic send_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (!req_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      check_cnt++;
      $display("FAIL req_ready_timeout got %b want 1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic [7:0] ra,
                         output logic ok);
    int n = 0;
    send_req(1'b0, a, 8'h00);
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    ok = rsp_valid; d = rsp_rdata; ra = rsp_addr;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    #1 rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({req_ready, busy, rsp_valid, read_en, write_en} !== 5'b01000)
      $display("FAIL reset_ctrl got %b want 01000", {req_ready, busy, rsp_valid, read_en, write_en});
    else pass_cnt++;
    check_cnt++;
    if ({rsp_rdata, rsp_addr, address_loc, data_in} !== 32'h0)
      $display("FAIL reset_data got %h want 00000000", {rsp_rdata, rsp_addr, address_loc, data_in});
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
`ifndef RAM_INIT_EN
    check_cnt++;
    if ({req_ready, busy} !== 2'b10)
      $display("FAIL release_first_edge got %b want 10", {req_ready, busy});
    else pass_cnt++;
`endif
    // asynchronous assertion mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({req_ready, busy} !== 2'b01)
      $display("FAIL async_reset got %b want 01", {req_ready, busy});
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    logic [7:0] d, ra; logic ok;
    send_req(1'b1, 8'h05, 8'hA5);
    check_cnt++;
    if ({write_en, read_en, req_ready, address_loc, data_in} !== {3'b100, 8'h05, 8'hA5})
      $display("FAIL wr_strobe got %b_%h_%h want 100_05_a5", {write_en, read_en, req_ready},
               address_loc, data_in);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if ({write_en, req_ready} !== 2'b01)
      $display("FAIL wr_one_cycle got %b want 01", {write_en, req_ready});
    else pass_cnt++;
    send_req(1'b0, 8'h05, 8'h00);
    check_cnt++;
    if ({read_en, write_en, address_loc} !== {2'b10, 8'h05})
      $display("FAIL rd_issue got %b_%h want 10_05", {read_en, write_en}, address_loc);
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if ({read_en, rsp_valid} !== 2'b00)
      $display("FAIL rd_capt got %b want 00", {read_en, rsp_valid});
    else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++;
    if ({rsp_valid, rsp_rdata, rsp_addr} !== {1'b1, 8'hA5, 8'h05})
      $display("FAIL rd_rsp got %b_%h_%h want 1_a5_05", rsp_valid, rsp_rdata, rsp_addr);
    else pass_cnt++;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL rsp_done got %b want 01", {rsp_valid, req_ready});
    else pass_cnt++;
    ok = 0;
    do_read(8'h05, d, ra, ok);
  endtask

  task automatic test_boundaries();
    logic [7:0] d, ra; logic ok;
    send_req(1'b1, 8'h00, 8'h11);
    send_req(1'b1, 8'hFF, 8'hEE);
    do_read(8'h00, d, ra, ok);
    check_cnt++;
    if ({ok, d, ra} !== {1'b1, 8'h11, 8'h00})
      $display("FAIL rd_addr0 got %b_%h_%h want 1_11_00", ok, d, ra);
    else pass_cnt++;
    do_read(8'hFF, d, ra, ok);
    check_cnt++;
    if ({ok, d, ra} !== {1'b1, 8'hEE, 8'hFF})
      $display("FAIL rd_addrff got %b_%h_%h want 1_ee_ff", ok, d, ra);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h01;
    @(posedge clk); #1;
    req_addr = 8'h11; req_wdata = 8'h02;
    check_cnt++;
    if ({write_en, address_loc, data_in} !== {1'b1, 8'h10, 8'h01})
      $display("FAIL b2b_first got %b_%h_%h want 1_10_01", write_en, address_loc, data_in);
    else pass_cnt++;
    @(posedge clk); #1;
    req_addr = 8'h12; req_wdata = 8'h03;
    check_cnt++;
    if ({write_en, req_ready, address_loc, data_in} !== {2'b01, 8'h10, 8'h01})
      $display("FAIL b2b_gap got %b_%h_%h want 01_10_01", {write_en, req_ready}, address_loc, data_in);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_cnt++;
    if ({write_en, address_loc, data_in} !== {1'b1, 8'h12, 8'h03})
      $display("FAIL b2b_second got %b_%h_%h want 1_12_03", write_en, address_loc, data_in);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_rsp_hold();
    int bad = 0;
    send_req(1'b0, 8'h05, 8'h00);
    @(posedge clk); #1; @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h44;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, rsp_rdata, rsp_addr, req_ready, read_en, write_en} !==
          {1'b1, 8'hA5, 8'h05, 3'b000}) bad++;
      @(posedge clk); #1;
    end
    check_cnt++;
    if (bad !== 0) $display("FAIL rsp_hold bad_cycles got %0d want 0", bad);
    else pass_cnt++;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check_cnt++;
    if ({rsp_valid, req_ready, busy} !== 3'b010)
      $display("FAIL rsp_release got %b want 010", {rsp_valid, req_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, ra; logic ok;
    int seen = 0;
    send_req(1'b1, 8'h30, 8'h5A);
    send_req(1'b1, 8'h40, 8'h77);
    send_req(1'b0, 8'h30, 8'h00);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({read_en, write_en, rsp_valid, busy} !== 4'b0001)
      $display("FAIL mid_reset_capt got %b want 0001", {read_en, write_en, rsp_valid, busy});
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check_cnt++;
    if (seen !== 0) $display("FAIL mid_reset_no_rsp got %0d want 0", seen);
    else pass_cnt++;
    do_read(8'h30, d, ra, ok);
    check_cnt++;
    if ({ok, d, ra} !== {1'b1, 8'h5A, 8'h30})
      $display("FAIL read_after_reset got %b_%h_%h want 1_5a_30", ok, d, ra);
    else pass_cnt++;
    // reset during WR cancels the pending write
    send_req(1'b1, 8'h40, 8'h99);
    #2 rst_n = 1'b0;
    #1;
    check_cnt++;
    if (write_en !== 1'b0) $display("FAIL wr_reset_strobe got %b want 0", write_en);
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
    do_read(8'h40, d, ra, ok);
    check_cnt++;
    if ({ok, d} !== {1'b1, 8'h77})
      $display("FAIL wr_cancelled got %b_%h want 1_77", ok, d);
    else pass_cnt++;
  endtask

`ifdef RAM_INIT_EN
  task automatic test_init();
    logic [7:0] d, ra; logic ok;
    int cnt = 0; int bad = 0;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
      if (!write_en || req_ready || address_loc !== 8'(cnt) || data_in !== 8'h00) bad++;
      cnt++;
    end
    check_cnt++;
    if (cnt !== 256 || bad !== 0) $display("FAIL init_sweep got %0d/%0d want 256/0", cnt, bad);
    else pass_cnt++;
    do_read(8'h80, d, ra, ok);
    check_cnt++;
    if ({ok, d} !== {1'b1, 8'h00}) $display("FAIL init_read got %b_%h want 1_00", ok, d);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef RAM_INIT_EN
    test_init();
`endif
    test_write_read();
    test_boundaries();
    test_back_to_back();
    test_rsp_hold();
    test_reset_mid();
    check_cnt++;
    if (overlap_cnt !== 0) $display("FAIL strobe_overlap got %0d want 0", overlap_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
